fft_reorder_buf: RTL and testbench

Ping-pong frame buffer that restores natural sample order at the FFT output. It accepts one frame of 2^TOTAL_STAGE complex samples written at scrambled (bit-reversed) addresses. It then streams the frame back out in ascending address order, 0 to 2^TOTAL_STAGE-1. While one bank is being read, the next frame is written into the other bank. The block sits between the last butterfly stage / address-reversal logic and the spectrum consumer.

---
 rtl/fft_reorder_buf.sv | 151 +++++++++++++++
 tb/tb_fft_reorder_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: frames written at scrambled addresses, read back in natural order.
// Build option FFT_REORDER_BITREV_EN: bit-reverse iaddr internally before it reaches the RAM.
module fft_reorder_buf #(
  parameter int unsigned TOTAL_STAGE = 10,
  parameter int unsigned CPLX_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ien,
  input  logic [TOTAL_STAGE-1:0] iaddr,
  input  logic [CPLX_WIDTH-1:0]  idata,
  input  logic                   ordy,
  output logic                   oen,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [CPLX_WIDTH-1:0]  odata,
  output logic                   ovf
);
  localparam int unsigned   AW   = TOTAL_STAGE;
  localparam int unsigned   N    = 1 << TOTAL_STAGE;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   rcnt_q, rcnt_d;
  logic            oen_q, oen_d;
  logic [AW-1:0]   oaddr_q, oaddr_d;
  logic [CPLX_WIDTH-1:0] odata_q;
  logic            ovf_q, ovf_d;

  logic            issue_c;
  logic            last_c;
  logic            wr_blocked_c;
  logic            we_c;
  logic [AW-1:0]   waddr_c;

  logic [CPLX_WIDTH-1:0] mem [2][N];

`ifdef FFT_REORDER_BITREV_EN
  always_comb begin
    waddr_c = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      waddr_c[i] = iaddr[AW-1-i];
    end
  end
`else
  assign waddr_c = iaddr;
`endif

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    oen_d   = 1'b0;
    oaddr_d = oaddr_q;
    ovf_d   = ovf_q;

    issue_c = (state_q == ST_READ) && ordy;
    last_c  = issue_c && (rcnt_q == LAST);
    // A bank being released by the reader this edge is already writable.
    wr_blocked_c = full_q[wb_q] && !(last_c && (rb_q == wb_q));
    we_c         = ien && !wr_blocked_c;

    case (state_q)
      ST_IDLE: begin
        if (full_q[rb_q]) begin
          state_d = ST_READ;
          rcnt_d  = '0;
        end
      end
      ST_READ: begin
        if (issue_c) begin
          oen_d   = 1'b1;
          oaddr_d = rcnt_q;
          rcnt_d  = rcnt_q + AW'(1);
          if (last_c) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            if (!full_q[~rb_q]) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write side; frame boundaries are defined only by the accepted-write count.
    if (we_c) begin
      wcnt_d = wcnt_q + AW'(1);
      if (wcnt_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (ien && wr_blocked_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      full_q  <= 2'b00;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      oen_q   <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      oen_q   <= oen_d;
      oaddr_q <= oaddr_d;
      ovf_q   <= ovf_d;
      if (issue_c) begin
        odata_q <= mem[rb_q][rcnt_q];
      end
    end
  end

  // Bank RAM write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_c && !rst) begin
      mem[wb_q][waddr_c] <= idata;
    end
  end

  assign oen   = oen_q;
  assign oaddr = oaddr_q;
  assign odata = odata_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf (TOTAL_STAGE=3): frame-queue reference model plus directed literal checks.
module tb_fft_reorder_buf;
  localparam int unsigned TS = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned N  = 1 << TS;

  logic          clk = 1'b0;
  logic          rst;
  logic          ien;
  logic [TS-1:0] iaddr;
  logic [CW-1:0] idata;
  logic          ordy;
  logic          oen;
  logic [TS-1:0] oaddr;
  logic [CW-1:0] odata;
  logic          ovf;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  fft_reorder_buf #(.TOTAL_STAGE(TS), .CPLX_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ien(ien), .iaddr(iaddr), .idata(idata),
    .ordy(ordy), .oen(oen), .oaddr(oaddr), .odata(odata), .ovf(ovf)
  );

  function automatic logic [TS-1:0] bitrev(input logic [TS-1:0] a);
    logic [TS-1:0] r;
    for (int i = 0; i < TS; i++) r[i] = a[TS-1-i];
    return r;
  endfunction

  // Address at which a given iaddr lands in the frame.
  function automatic logic [TS-1:0] store_addr(input logic [TS-1:0] a);
`ifdef FFT_REORDER_BITREV_EN
    return bitrev(a);
`else
    return a;
`endif
  endfunction

  // iaddr for the directed scenario that should yield odata = bitrev(oaddr).
  function automatic logic [TS-1:0] s1_addr(input int i);
`ifdef FFT_REORDER_BITREV_EN
    return TS'(i);
`else
    return bitrev(TS'(i));
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of completed frames (at most two held), a partial frame,
  // and a reader that walks the oldest frame one index per ordy cycle.
  logic [CW-1:0] m_held[$];
  logic [CW-1:0] m_part [N];
  int            m_wcnt   = 0;
  int            m_idx    = 0;
  bit            m_active = 0;
  int            m_nfr;
  bit            m_issue, m_rel, m_acc;
  bit            e_oen = 0, e_ovf = 0;
  logic [TS-1:0] e_oaddr = '0;
  logic [CW-1:0] e_odata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_held.delete();
      m_wcnt = 0; m_idx = 0; m_active = 0;
      e_oen = 0; e_oaddr = '0; e_odata = '0; e_ovf = 0;
    end else begin
      m_nfr   = m_held.size() / N;
      m_issue = m_active && ordy;
      m_rel   = m_issue && (m_idx == N - 1);
      m_acc   = ien && ((m_nfr < 2) || m_rel);
      e_oen   = m_issue;
      if (m_issue) begin
        e_oaddr = TS'(m_idx);
        e_odata = m_held[m_idx];
        m_idx   = (m_idx + 1) % N;
      end
      if (ien && !m_acc) e_ovf = 1;
      if (m_rel) for (int k = 0; k < N; k++) void'(m_held.pop_front());
      m_active = m_active ? (m_rel ? (m_nfr >= 2) : 1'b1) : (m_nfr > 0);
      if (m_acc) begin
        m_part[store_addr(iaddr)] = idata;
        if (m_wcnt == N - 1) begin
          for (int k = 0; k < N; k++) m_held.push_back(m_part[k]);
          m_wcnt = 0;
        end else begin
          m_wcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("oen", 32'(oen), 32'(e_oen));
      check("ovf", 32'(ovf), 32'(e_ovf));
      if (e_oen) begin
        check("oaddr", 32'(oaddr), 32'(e_oaddr));
        check("odata", 32'(odata), 32'(e_odata));
      end
    end
  end

  task automatic drive(input bit r, input bit en, input logic [TS-1:0] a,
                       input logic [CW-1:0] d, input bit rd);
    @(negedge clk);
    rst = r; ien = en; iaddr = a; idata = d; ordy = rd;
  endtask

  // Write a random sample; addresses form a per-frame permutation so no stale RAM is read.
  logic [TS-1:0] mask = '0;
  task automatic rand_write(input bit r, input bit rd);
    @(negedge clk);
    if (m_wcnt == 0) mask = TS'($urandom);
    rst = r; ien = 1'b1; iaddr = TS'(m_wcnt) ^ mask; idata = CW'($urandom); ordy = rd;
  endtask

  logic [CW-1:0] exp1 [N] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
  bit            cap_oen [11];
  logic [CW-1:0] cap_od  [11];
  int            cnt, first, last;
  bit            found;
  int            ien_pct, ordy_pct;

  initial begin
    rst = 1'b1; ien = 1'b0; ordy = 1'b0; iaddr = '0; idata = '0;
    repeat (2) @(negedge clk);
    check("rst_oen", 32'(oen), 32'd0);
    check("rst_oaddr", 32'(oaddr), 32'd0);
    check("rst_odata", 32'(odata), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    chk_en = 1;

    // Scrambled single frame, ordy held high.
    for (int i = 0; i < N; i++) drive(0, 1, s1_addr(i), CW'(i), 1);
    for (int j = 0; j < 11; j++) begin
      drive(0, 0, '0, '0, 1);
      cap_oen[j] = oen; cap_od[j] = odata;
    end
    check("s1_oen_e0", 32'(cap_oen[0]), 32'd0);
    check("s1_oen_e1", 32'(cap_oen[1]), 32'd0);
    check("s1_oen_e10", 32'(cap_oen[10]), 32'd0);
    for (int j = 2; j < 10; j++) begin
      check("s1_oen", 32'(cap_oen[j]), 32'd1);
      check("s1_odata", 32'(cap_od[j]), 32'(exp1[j-2]));
    end
    check("s1_ovf", 32'(ovf), 32'd0);

    // Back-to-back frames with continuous input.
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (c < 2 * N) rand_write(0, 1); else drive(0, 0, '0, '0, 1);
      if (oen) begin cnt++; if (first < 0) first = c; last = c; end
    end
    check("b2b_count", 32'(cnt), 32'd16);
    check("b2b_contig", 32'(last - first + 1), 32'd16);
    check("b2b_ovf", 32'(ovf), 32'd0);

    // Stalled reader: ordy alternates.
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < N) drive(0, 1, s1_addr(c), CW'(c), (c % 2) == 0);
      else drive(0, 0, '0, '0, (c % 2) == 0);
      if (oen) begin check("stall_order", 32'(oaddr), 32'(cnt % N)); cnt++; end
    end
    check("stall_count", 32'(cnt), 32'd8);

    // Overflow: three frames with the reader stalled.
    for (int c = 0; c < 2 * N; c++) rand_write(0, 0);
    rand_write(0, 0);
    check("ovf_before", 32'(ovf), 32'd0);
    drive(0, 0, '0, '0, 0);
    check("ovf_after", 32'(ovf), 32'd1);
    for (int c = 1; c < N; c++) rand_write(0, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      drive(0, 0, '0, '0, 1);
      if (oen) cnt++;
    end
    check("ovf_drain_count", 32'(cnt), 32'd16);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-read at oaddr 3.
    drive(1, 0, '0, '0, 0);
    for (int c = 0; c < N; c++) rand_write(0, 1);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      drive(0, 0, '0, '0, 1);
      if (oen && oaddr == TS'(3)) found = 1;
    end
    check("mid_read_reached", 32'(found), 32'd1);
    rst = 1'b1;
    drive(0, 0, '0, '0, 1);
    check("mrst_oen", 32'(oen), 32'd0);
    check("mrst_oaddr", 32'(oaddr), 32'd0);
    check("mrst_odata", 32'(odata), 32'd0);
    check("mrst_ovf", 32'(ovf), 32'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin drive(0, 0, '0, '0, 1); if (oen) cnt++; end
    check("mrst_quiet", 32'(cnt), 32'd0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < N) rand_write(0, 1); else drive(0, 0, '0, '0, 1);
      if (oen) begin check("mrst_order", 32'(oaddr), 32'(cnt)); cnt++; end
    end
    check("mrst_count", 32'(cnt), 32'd8);

    // Randomized traffic with occasional resets.
    ien_pct = 70; ordy_pct = 60;
    for (int c = 0; c < 4000; c++) begin
      bit r, rd;
      if (c % 400 == 0) begin
        ien_pct  = $urandom_range(20, 100);
        ordy_pct = $urandom_range(0, 100);
      end
      r  = ($urandom_range(0, 599) == 0);
      rd = ($urandom_range(0, 99) < ordy_pct);
      if ($urandom_range(0, 99) < ien_pct) rand_write(r, rd);
      else drive(r, 0, '0, '0, rd);
    end
    for (int c = 0; c < 30; c++) drive(0, 0, '0, '0, 1);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
